// File: rtl/mac_sequencer.sv
// mac_sequencer: runs one neuron evaluation on the mac datapath (clear, weight load, input accumulate, latency wait, capture).
// Define THRESH_FIRE_EN to enable the threshold spike output; otherwise spike is tied low.
module mac_sequencer #(
  parameter int DW      = 8,
  parameter int AW      = 16,
  parameter int NTAP    = 4,
  parameter int MAC_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            keep_w,
  input  logic            abort,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  output logic [DW-1:0]   mac_in,
  output logic [NTAP-1:0] mac_ld_w,
  output logic            mac_ld,
  output logic            mac_clken,
  output logic            mac_clr,
  input  logic [AW-1:0]   mac_out,
  output logic            busy,
  output logic [AW-1:0]   result,
  output logic            result_valid,
  output logic            spike,
  input  logic [AW-1:0]   thresh
);

  localparam int TW = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LDW, S_LDX, S_WAIT, S_CAP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          keep_q, keep_d;
  logic [DW-1:0] last_q, last_d;
  logic [AW-1:0] result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          spike_q, spike_d;
  logic          hs;
  logic          last_tap;
  logic          fire;

  // Abort suppresses the handshake so no strobe fires on the cancelling cycle.
  assign s_ready  = ((state_q == S_LDW) || (state_q == S_LDX)) && !abort;
  assign hs       = s_valid && s_ready;
  assign last_tap = (tap_q == TW'(NTAP - 1));
  assign mac_in   = hs ? s_data : last_q;

  generate
    for (genvar gi = 0; gi < NTAP; gi++) begin : g_ld_w
      assign mac_ld_w[gi] = hs && (state_q == S_LDW) && (tap_q == TW'(gi));
    end
  endgenerate

`ifdef THRESH_FIRE_EN
  assign fire = (mac_out >= thresh);
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign fire          = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    tap_d          = tap_q;
    lat_d          = lat_q;
    keep_d         = keep_q;
    last_d         = last_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    spike_d        = 1'b0;
    mac_ld         = 1'b0;
    mac_clken      = 1'b0;
    mac_clr        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          keep_d  = keep_w;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        mac_clr = 1'b1;
        tap_d   = '0;
        state_d = keep_q ? S_LDX : S_LDW;
      end
      S_LDW: begin
        if (hs) begin
          last_d = s_data;
          if (last_tap) begin
            tap_d   = '0;
            state_d = S_LDX;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      S_LDX: begin
        if (hs) begin
          mac_ld    = 1'b1;
          mac_clken = 1'b1;
          last_d    = s_data;
          if (last_tap) begin
            tap_d   = '0;
            lat_d   = LW'(MAC_LAT - 1);
            state_d = S_WAIT;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        mac_clken = 1'b1;
        if (lat_q == '0) state_d = S_CAP;
        else             lat_d   = lat_q - 1'b1;
      end
      S_CAP: begin
        result_d       = mac_out;
        result_valid_d = 1'b1;
        spike_d        = fire;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d        = S_IDLE;
      tap_d          = '0;
      result_d       = result_q;
      result_valid_d = 1'b0;
      spike_d        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      tap_q          <= '0;
      lat_q          <= '0;
      keep_q         <= 1'b0;
      last_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      spike_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      tap_q          <= tap_d;
      lat_q          <= lat_d;
      keep_q         <= keep_d;
      last_q         <= last_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      spike_q        <= spike_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign spike        = spike_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Testbench for mac_sequencer: directed plus random evaluations against a stimulus-level reference
// (dot product of weights and inputs, latency formula, threshold rule) with a small mac datapath model.
module tb_mac_sequencer;
  localparam int DW = 8, AW = 16, NTAP = 4, MAC_LAT = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0, keep_w = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [DW-1:0]   s_data = '0;
  logic            s_ready;
  logic [DW-1:0]   mac_in;
  logic [NTAP-1:0] mac_ld_w;
  logic            mac_ld, mac_clken, mac_clr;
  logic [AW-1:0]   mac_out;
  logic            busy;
  logic [AW-1:0]   result;
  logic            result_valid, spike;
  logic [AW-1:0]   thresh = '0;

  mac_sequencer #(.DW(DW), .AW(AW), .NTAP(NTAP), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .keep_w(keep_w), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mac_in(mac_in), .mac_ld_w(mac_ld_w), .mac_ld(mac_ld), .mac_clken(mac_clken),
    .mac_clr(mac_clr), .mac_out(mac_out), .busy(busy), .result(result),
    .result_valid(result_valid), .spike(spike), .thresh(thresh)
  );

  always #5 clk = ~clk;

  // Behavioural mac datapath reacting to the sequencer strobes.
  logic [DW-1:0] mw [NTAP];
  logic [AW-1:0] acc = '0;
  int            xi = 0;
  bit            force_en = 1'b0;
  logic [AW-1:0] force_val = '0;
  assign mac_out = force_en ? force_val : acc;

  always @(posedge clk) begin
    if (mac_clr) begin
      acc <= '0;
      xi  <= 0;
    end
    for (int k = 0; k < NTAP; k++)
      if (mac_ld_w[k]) mw[k] <= mac_in;
    if (mac_ld) begin
      acc <= acc + {8'd0, mw[xi % NTAP]} * {8'd0, mac_in};
      xi  <= xi + 1;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [DW-1:0] wv [NTAP];
  logic [DW-1:0] xv [NTAP];
  logic [DW-1:0] wref [NTAP];
  bit            w_loaded = 1'b0;
  logic [AW-1:0] exp_result = '0;

  task automatic run_eval(input bit keep, input int stall_at, input int stall_len,
                          input bit use_force, input logic [AW-1:0] fval,
                          input logic [AW-1:0] th, input string name);
    int nb, hs, stall_left, lat, exp_lat;
    logic [AW-1:0] expected, mo;
    logic [DW-1:0] last_byte;
    bit exp_spike, wphase;
    nb = keep ? NTAP : 2 * NTAP;
    force_en  = use_force;
    force_val = fval;
    thresh    = th;
    if (!keep) wref = wv;
    expected = '0;
    for (int k = 0; k < NTAP; k++) expected = expected + {8'd0, wref[k]} * {8'd0, xv[k]};
    mo = use_force ? fval : expected;
`ifdef THRESH_FIRE_EN
    exp_spike = (mo >= th);
`else
    exp_spike = 1'b0;
`endif
    @(negedge clk);
    start = 1'b1; keep_w = keep; s_valid = 1'b0;
    hs = 0; stall_left = stall_len; lat = -1; last_byte = mac_in;
    for (int cyc = 1; cyc <= 100 && lat < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0; keep_w = 1'b0;
      if (hs < nb && !(hs == stall_at && stall_left > 0)) begin
        s_valid = 1'b1;
        s_data  = keep ? xv[hs] : (hs < NTAP ? wv[hs] : xv[hs - NTAP]);
      end else begin
        s_valid = 1'b0;
        if (hs < nb && hs == stall_at) stall_left--;
      end
      #1;
      if (cyc == 1) check("busy_clr", busy, 1);
      if (s_valid && s_ready) begin
        wphase = !keep && hs < NTAP;
        check("mac_in", mac_in, s_data);
        if (wphase) begin
          check("ld_w_onehot", mac_ld_w, 32'(1) << hs);
          check("ld_in_wphase", mac_ld, 0);
        end else begin
          check("ld_x", {mac_ld, mac_clken}, 2'b11);
          check("ld_w_in_xphase", mac_ld_w, 0);
        end
        last_byte = s_data;
        hs++;
      end else if (hs > 0 && hs < nb && !s_valid) begin
        check("stall_strobes", {mac_ld_w, mac_ld, mac_clken}, 0);
        check("stall_mac_in", mac_in, last_byte);
      end
      if (result_valid) lat = cyc;
    end
    s_valid = 1'b0;
    exp_lat = 3 + (keep ? 0 : NTAP) + NTAP + MAC_LAT + stall_len;
    check("latency", lat, exp_lat);
    check("result", result, mo);
    check("spike", spike, exp_spike);
    check("busy_done", busy, 0);
    @(negedge clk); #1;
    check("rv_pulse", {result_valid, spike}, 0);
    check("result_hold", result, mo);
    exp_result = mo;
    if (!keep) w_loaded = 1'b1;
    force_en = 1'b0;
    $display("[TB] eval %s keep=%0d stall=%0d@%0d lat=%0d result=0x%04h spike=%0b",
             name, keep, stall_len, stall_at, lat, result, exp_spike);
  endtask

  task automatic abort_run(input int at_hs);
    int hs;
    bit rv_seen, busy_seen;
    @(negedge clk);
    start = 1'b1; keep_w = 1'b0; s_valid = 1'b0;
    hs = 0;
    for (int cyc = 0; cyc < 20 && !abort; cyc++) begin
      @(negedge clk);
      start = 1'b0; s_valid = 1'b1; s_data = wv[hs % NTAP];
      if (hs == at_hs) begin
        abort = 1'b1;
        start = 1'b1;
      end
      #1;
      if (!abort && s_valid && s_ready) hs++;
    end
    @(negedge clk);
    abort = 1'b0; start = 1'b0; s_valid = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    rv_seen = 1'b0; busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk); #1;
      rv_seen   |= result_valid;
      busy_seen |= busy;
    end
    check("abort_no_rv", rv_seen, 0);
    check("abort_start_ignored", busy_seen, 0);
    check("abort_result", result, exp_result);
    w_loaded = 1'b0;
    $display("[TB] abort at handshake %0d result=0x%04h", at_hs + 1, result);
  endtask

  initial begin
    int keep, sat, slen;
    // Reset held with start asserted.
    rst = 1'b0; start = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_strobes", {s_ready, mac_ld_w, mac_ld, mac_clken, mac_clr}, 0);
    check("rst_mac_in", mac_in, 0);
    check("rst_result", {result, result_valid, spike}, 0);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    $display("[TB] reset outputs checked");

    wv = '{8'd1, 8'd2, 8'd3, 8'd4};
    xv = '{8'd5, 8'd6, 8'd7, 8'd8};
    run_eval(0, -1, 0, 0, '0, 16'hFFFF, "full");
    xv = '{8'd1, 8'd1, 8'd1, 8'd1};
    run_eval(1, -1, 0, 0, '0, 16'hFFFF, "keep_w");
    xv = '{8'd5, 8'd6, 8'd7, 8'd8};
    run_eval(0, NTAP + 2, 3, 0, '0, 16'hFFFF, "stall");
    run_eval(1, -1, 0, 1, 16'h0046, 16'h0046, "thresh_eq");
    run_eval(1, -1, 0, 1, 16'h0045, 16'h0046, "thresh_below");

    abort_run(2);

    // start together with abort in IDLE stays idle.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    check("idle_abort_wins", busy, 0);
    $display("[TB] start+abort in idle busy=%0b", busy);

    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < NTAP; k++) begin
        wv[k] = DW'($urandom);
        xv[k] = DW'($urandom);
      end
      keep = (w_loaded && $urandom_range(0, 1) == 1) ? 1 : 0;
      if ($urandom_range(0, 1) == 1) begin
        sat  = $urandom_range(1, (keep != 0 ? NTAP : 2 * NTAP) - 1);
        slen = $urandom_range(1, 4);
      end else begin
        sat  = -1;
        slen = 0;
      end
      run_eval(keep != 0, sat, slen, 0, '0, AW'($urandom), "random");
    end

    // Reset mid-evaluation clears result and returns to idle.
    @(negedge clk);
    start = 1'b1; keep_w = 1'b0;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 8'h11;
    repeat (3) @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_result", {result, result_valid}, 0);
    w_loaded = 1'b0; exp_result = '0;
    $display("[TB] mid-run reset result=0x%04h busy=%0b", result, busy);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
